// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler.
//   - FSM state encoding used by alu_sched
//   - Opcode constants understood by the attached ALU
//   - Default opcode count, datapath widths and a small one-hot helper
package alu_pkg;

   localparam int unsigned NUM_REQ     = 2;
   localparam int unsigned OPC_W       = 5;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned NUM_OPS_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
   localparam logic [OPC_W-1:0] OP_ADDC = 5'd1;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'd2;
   localparam logic [OPC_W-1:0] OP_SUBC = 5'd3;
   localparam logic [OPC_W-1:0] OP_AND  = 5'd4;
   localparam logic [OPC_W-1:0] OP_OR   = 5'd5;
   localparam logic [OPC_W-1:0] OP_XOR  = 5'd6;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'd7;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'd8;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'd9;
   localparam logic [OPC_W-1:0] OP_SRA  = 5'd10;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'd11;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'd12;
   localparam logic [OPC_W-1:0] OP_INC  = 5'd13;
   localparam logic [OPC_W-1:0] OP_DEC  = 5'd14;
   localparam logic [OPC_W-1:0] OP_NEG  = 5'd15;

   // Requester index to one-hot response vector.
   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst   single clock, synchronous active-high reset
//   valid[1:0] request valid per requester
//   accept     the granted request was taken this cycle
//   grant[1:0] one-hot (or zero) grant
// A lone requester always wins; on a tie the requester not served last wins.
// The "last served" pointer only moves when a grant is accepted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant
);

   // Index of the requester served most recently; reset to 1 so requester 0
   // wins the first tie.
   logic r_last;

   always_comb begin
      grant = 2'b00;
      unique case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = r_last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (accept) begin
         r_last <= grant[1];
      end
   end

endmodule

// File: rtl/alu_sched.sv
// Scheduler sharing one multi-cycle ALU between two requesters.
// Flow: IDLE (accept a request) -> ISSUE (one-cycle alu_enable) -> WAIT
// (count LATENCY cycles, capture alu_out) -> RESP (hold until owner accepts).
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   req_valid/req_ready[1:0]  request handshake, bit i = requester i
//   req_opcode[9:0]           5-bit opcode per requester
//   req_a/req_b[63:0]         32-bit operands per requester
//   rsp_valid/rsp_ready[1:0]  response handshake, valid is one-hot to owner
//   rsp_data[31:0], rsp_err   result and illegal-opcode flag
//   alu_opcode/alu_enable/alu_a/alu_b  ALU command, alu_out ALU result
//   busy                      scheduler not in IDLE
// Optional feature: define ALU_SCHED_OPCHK_EN to answer opcodes >= NUM_OPS
// directly with rsp_err=1, rsp_data=0 without touching the ALU.
module alu_sched
   import alu_pkg::*;
#(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned NUM_OPS = NUM_OPS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [9:0]  req_opcode,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [4:0]  alu_opcode,
   output logic        alu_enable,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_out,
   output logic        busy
);

   if (LATENCY < 1 || LATENCY > 15 || NUM_OPS < 1 || NUM_OPS > 32) begin : g_bad_param
      $error("alu_sched: LATENCY must be 1..15 and NUM_OPS 1..32");
   end

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         w_grant;
   logic               w_accept;
   logic               w_sel;
   logic [OPC_W-1:0]   w_sel_op;
   logic [DATA_W-1:0]  w_sel_a;
   logic [DATA_W-1:0]  w_sel_b;
   logic               w_illegal;

   logic               r_owner;
   logic [OPC_W-1:0]   r_op;
   logic [DATA_W-1:0]  r_a;
   logic [DATA_W-1:0]  r_b;
   logic [CNT_W-1:0]   r_cnt;
   logic [DATA_W-1:0]  r_rsp_data;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .valid  (req_valid),
      .accept (w_accept),
      .grant  (w_grant)
   );

   // Grant is one-hot, so bit 1 is the winning index.
   assign w_sel    = w_grant[1];
   assign w_sel_op = w_sel ? req_opcode[9:5] : req_opcode[4:0];
   assign w_sel_a  = w_sel ? req_a[63:32]    : req_a[31:0];
   assign w_sel_b  = w_sel ? req_b[63:32]    : req_b[31:0];
   assign w_accept = |(req_valid & req_ready);

`ifdef ALU_SCHED_OPCHK_EN
   localparam logic [OPC_W:0] NUM_OPS_W = (OPC_W + 1)'(NUM_OPS);
   logic r_rsp_err;
   assign w_illegal = ({1'b0, w_sel_op} >= NUM_OPS_W);
   assign rsp_err   = r_rsp_err;
`else
   assign w_illegal = 1'b0;
   assign rsp_err   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 2'b00;
      rsp_valid   = 2'b00;
      alu_enable  = 1'b0;
      busy        = (r_state != IDLE);
      unique case (r_state)
         IDLE: begin
            // Gated by rst so nothing is taken on a reset cycle.
            req_ready = rst ? 2'b00 : w_grant;
            if (w_accept) begin
               w_state_nxt = w_illegal ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            alu_enable  = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = idx_to_onehot(r_owner);
            if (rsp_ready[r_owner]) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner    <= 1'b0;
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_cnt      <= '0;
         r_rsp_data <= '0;
`ifdef ALU_SCHED_OPCHK_EN
         r_rsp_err  <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_owner <= w_sel;
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
`ifdef ALU_SCHED_OPCHK_EN
            if (w_illegal) begin
               r_rsp_data <= '0;
               r_rsp_err  <= 1'b1;
            end
`endif
         end
         if (r_state == ISSUE) begin
            r_cnt <= LAT_LOAD;
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               r_rsp_data <= alu_out;
`ifdef ALU_SCHED_OPCHK_EN
               r_rsp_err  <= 1'b0;
`endif
            end
         end
      end
   end

   // Command registers only change on accept, so they stay put ISSUE..WAIT.
   assign alu_opcode = r_op;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched. Two instances (LATENCY 1 and 4) share the
// same stimulus; each has its own bench-side ALU and transaction-level model.
module tb_alu_sched;
   import alu_pkg::*;

   localparam int NI = 2;
   localparam int unsigned LAT0 = 1;
   localparam int unsigned LAT1 = 4;
`ifdef ALU_SCHED_OPCHK_EN
   localparam bit OPCHK = 1'b1;
`else
   localparam bit OPCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [9:0]  req_opcode;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [1:0]  rsp_ready;

   logic [1:0]  req_ready_o  [NI];
   logic [1:0]  rsp_valid_o  [NI];
   logic [31:0] rsp_data_o   [NI];
   logic        rsp_err_o    [NI];
   logic [4:0]  alu_opcode_o [NI];
   logic        alu_enable_o [NI];
   logic [31:0] alu_a_o      [NI];
   logic [31:0] alu_b_o      [NI];
   logic [31:0] alu_out_i    [NI];
   logic        busy_o       [NI];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int en_cnt [NI];
   logic [32:0] log_q [$];

   always #5 clk = ~clk;

   alu_sched #(.LATENCY(LAT0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[0]),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data_o[0]),
      .rsp_err(rsp_err_o[0]), .alu_opcode(alu_opcode_o[0]), .alu_enable(alu_enable_o[0]),
      .alu_a(alu_a_o[0]), .alu_b(alu_b_o[0]), .alu_out(alu_out_i[0]), .busy(busy_o[0])
   );

   alu_sched #(.LATENCY(LAT1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[1]),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data_o[1]),
      .rsp_err(rsp_err_o[1]), .alu_opcode(alu_opcode_o[1]), .alu_enable(alu_enable_o[1]),
      .alu_a(alu_a_o[1]), .alu_b(alu_b_o[1]), .alu_out(alu_out_i[1]), .busy(busy_o[1])
   );

   function automatic int unsigned lat_of(input int k);
      return (k == 0) ? LAT0 : LAT1;
   endfunction

   function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_XOR:  return a ^ b;
         default: return a | b;
      endcase
   endfunction

   // Lone requester wins; on a tie the one not served last wins.
   function automatic logic [1:0] grant_of(input logic [1:0] v, input logic last);
      if (v == 2'b11) return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", name, idx, cyc, got, exp);
      end
   endtask

   // Bench-side ALU: result valid exactly LATENCY cycles after the enable cycle.
   int unsigned alu_cnt [NI];
   logic [31:0] alu_res [NI];

   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            alu_cnt[k] <= 0;
         end else if (alu_enable_o[k]) begin
            alu_res[k] <= alu_fn(alu_opcode_o[k], alu_a_o[k], alu_b_o[k]);
            alu_cnt[k] <= lat_of(k);
         end else if (alu_cnt[k] > 0) begin
            alu_cnt[k] <= alu_cnt[k] - 1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NI; k++) begin
         alu_out_i[k] = (alu_cnt[k] == 1) ? alu_res[k] : 32'hDEAD_BEEF;
      end
   end

   // Transaction model: one in-flight op, response window starts at a fixed cycle.
   bit          m_act  [NI];
   bit          m_ill  [NI];
   logic        m_own  [NI];
   logic        m_last [NI];
   int          m_t0   [NI];
   int          m_rs   [NI];
   logic [4:0]  m_op   [NI];
   logic [31:0] m_a    [NI];
   logic [31:0] m_b    [NI];
   logic [31:0] m_data [NI];

   always @(posedge clk) begin : p_model
      logic [1:0] g;
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            m_act[k]  = 1'b0;
            m_last[k] = 1'b1;
         end else if (!m_act[k]) begin
            g = grant_of(req_valid, m_last[k]);
            if (g != 2'b00) begin
               m_act[k]  = 1'b1;
               m_own[k]  = g[1];
               m_last[k] = g[1];
               m_t0[k]   = cyc;
               m_op[k]   = g[1] ? req_opcode[9:5] : req_opcode[4:0];
               m_a[k]    = g[1] ? req_a[63:32]    : req_a[31:0];
               m_b[k]    = g[1] ? req_b[63:32]    : req_b[31:0];
               m_ill[k]  = OPCHK && (m_op[k] >= 5'd16);
               m_rs[k]   = m_ill[k] ? cyc + 1 : cyc + 2 + int'(lat_of(k));
               m_data[k] = m_ill[k] ? 32'd0 : alu_fn(m_op[k], m_a[k], m_b[k]);
            end
         end else if (cyc >= m_rs[k] && rsp_ready[m_own[k]]) begin
            m_act[k] = 1'b0;
         end
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin : p_cmp
      bit         in_resp;
      logic [1:0] exp_rdy;
      if (!rst) begin
         for (int k = 0; k < NI; k++) begin
            in_resp = m_act[k] && (cyc >= m_rs[k]);
            exp_rdy = m_act[k] ? 2'b00 : grant_of(req_valid, m_last[k]);
            chk("busy", k, 32'(busy_o[k]), 32'(m_act[k]));
            chk("req_ready", k, 32'(req_ready_o[k]), 32'(exp_rdy));
            chk("alu_enable", k, 32'(alu_enable_o[k]),
                32'(m_act[k] && !m_ill[k] && cyc == m_t0[k] + 1));
            chk("rsp_valid", k, 32'(rsp_valid_o[k]),
                in_resp ? (m_own[k] ? 32'd2 : 32'd1) : 32'd0);
            if (in_resp) begin
               chk("rsp_data", k, rsp_data_o[k], m_data[k]);
               chk("rsp_err", k, 32'(rsp_err_o[k]), 32'(m_ill[k]));
            end
            if (m_act[k] && !m_ill[k] && cyc > m_t0[k] && cyc < m_rs[k]) begin
               chk("alu_opcode", k, 32'(alu_opcode_o[k]), 32'(m_op[k]));
               chk("alu_a", k, alu_a_o[k], m_a[k]);
               chk("alu_b", k, alu_b_o[k], m_b[k]);
            end
            if (alu_enable_o[k]) en_cnt[k]++;
         end
         if ((rsp_valid_o[0] & rsp_ready) != 2'b00) begin
            log_q.push_back({rsp_valid_o[0][1], rsp_data_o[0]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_o[0] || busy_o[1]) && n < 50) begin
         tick();
         n++;
      end
      chk("idle_wait", 0, 32'(n >= 50), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      req_opcode = '0; req_a = '0; req_b = '0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("rst_busy", k, 32'(busy_o[k]), 32'd0);
         chk("rst_rsp_valid", k, 32'(rsp_valid_o[k]), 32'd0);
         chk("rst_rsp_data", k, rsp_data_o[k], 32'd0);
         chk("rst_rsp_err", k, 32'(rsp_err_o[k]), 32'd0);
         chk("rst_alu_enable", k, 32'(alu_enable_o[k]), 32'd0);
         chk("rst_alu_opcode", k, 32'(alu_opcode_o[k]), 32'd0);
         chk("rst_alu_a", k, alu_a_o[k], 32'd0);
         chk("rst_alu_b", k, alu_b_o[k], 32'd0);
         chk("rst_req_ready", k, 32'(req_ready_o[k]), 32'd0);
      end

      // Single add from requester 0: 5 + 7 = 12.
      en_cnt[0] = 0; en_cnt[1] = 0;
      tick();
      req_valid = 2'b01; req_opcode = {5'd0, OP_ADD};
      req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd7}; rsp_ready = 2'b11;
      tick(); req_valid = 2'b00;
      tick();
      @(negedge clk);
      chk("add_early", 0, 32'(rsp_valid_o[0]), 32'd0);
      tick();
      @(negedge clk);
      chk("add_valid_l1", 0, 32'(rsp_valid_o[0]), 32'd1);
      chk("add_data_l1", 0, rsp_data_o[0], 32'd12);
      tick(); tick();
      @(negedge clk);
      chk("add_early_l4", 1, 32'(rsp_valid_o[1]), 32'd0);
      tick();
      @(negedge clk);
      chk("add_valid_l4", 1, 32'(rsp_valid_o[1]), 32'd1);
      chk("add_data_l4", 1, rsp_data_o[1], 32'd12);
      wait_idle();
      chk("add_en_pulses", 0, 32'(en_cnt[0]), 32'd1);
      chk("add_en_pulses", 1, 32'(en_cnt[1]), 32'd1);

      // Both requesters always valid: req0 computes 1+2, req1 computes 100-1.
      log_q.delete();
      tick();
      req_valid = 2'b11; req_opcode = {OP_SUB, OP_ADD};
      req_a = {32'd100, 32'd1}; req_b = {32'd1, 32'd2}; rsp_ready = 2'b11;
      repeat (24) tick();
      req_valid = 2'b00;
      wait_idle();
      chk("rr_count", 0, 32'(log_q.size() >= 4), 32'd1);
      if (log_q.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("rr_owner", i, 32'(log_q[i][32]), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_data", i, log_q[i][31:0], (i % 2 == 0) ? 32'd99 : 32'd3);
         end
      end

      // Response stall: requester 1 XOR, non-owner rsp_ready only.
      en_cnt[0] = 0; en_cnt[1] = 0;
      tick();
      req_valid = 2'b10; req_opcode = {OP_XOR, 5'd0};
      req_a = {32'h0000_00F0, 32'd0}; req_b = {32'h0000_000F, 32'd0}; rsp_ready = 2'b01;
      tick(); req_valid = 2'b11;
      tick(); tick();
      @(negedge clk);
      chk("stall_valid_a", 0, 32'(rsp_valid_o[0]), 32'd2);
      chk("stall_data_a", 0, rsp_data_o[0], 32'h0000_00FF);
      repeat (5) tick();
      @(negedge clk);
      chk("stall_valid_b", 0, 32'(rsp_valid_o[0]), 32'd2);
      chk("stall_data_b", 0, rsp_data_o[0], 32'h0000_00FF);
      chk("stall_ready", 0, 32'(req_ready_o[0]), 32'd0);
      chk("stall_en_pulses", 0, 32'(en_cnt[0]), 32'd1);
      tick();
      req_valid = 2'b00; rsp_ready = 2'b11;
      wait_idle();

      // Reset while the LATENCY=4 instance is in WAIT.
      tick();
      req_valid = 2'b01; req_opcode = {5'd0, OP_ADD};
      req_a = {32'd0, 32'd1}; req_b = {32'd0, 32'd1}; rsp_ready = 2'b00;
      tick(); req_valid = 2'b00;
      tick();
      tick(); rst = 1'b1;
      tick(); rst = 1'b0; req_valid = 2'b11; rsp_ready = 2'b11;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("midrst_busy", k, 32'(busy_o[k]), 32'd0);
         chk("midrst_rsp_valid", k, 32'(rsp_valid_o[k]), 32'd0);
         chk("midrst_alu_a", k, alu_a_o[k], 32'd0);
         chk("midrst_tie_grant", k, 32'(req_ready_o[k]), 32'd1);
      end
      tick(); req_valid = 2'b00;
      wait_idle();
      chk("midrst_data", 0, rsp_data_o[0], 32'd2);

      // Opcode beyond the implemented set: 3 | 4 = 7 from the bench ALU when issued.
      en_cnt[0] = 0; en_cnt[1] = 0;
      tick();
      req_valid = 2'b01; req_opcode = {5'd0, 5'd20};
      req_a = {32'd0, 32'd3}; req_b = {32'd0, 32'd4}; rsp_ready = 2'b11;
      tick(); req_valid = 2'b00;
`ifdef ALU_SCHED_OPCHK_EN
      @(negedge clk);
      chk("ill_valid", 0, 32'(rsp_valid_o[0]), 32'd1);
      chk("ill_err", 0, 32'(rsp_err_o[0]), 32'd1);
      chk("ill_data", 0, rsp_data_o[0], 32'd0);
      wait_idle();
      chk("ill_en_pulses", 0, 32'(en_cnt[0]), 32'd0);
      chk("ill_en_pulses", 1, 32'(en_cnt[1]), 32'd0);
`else
      tick(); tick();
      @(negedge clk);
      chk("op20_valid", 0, 32'(rsp_valid_o[0]), 32'd1);
      chk("op20_err", 0, 32'(rsp_err_o[0]), 32'd0);
      chk("op20_data", 0, rsp_data_o[0], 32'd7);
      wait_idle();
      chk("op20_en_pulses", 0, 32'(en_cnt[0]), 32'd1);
`endif

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter LATENCY, default 1, ALU cycles from enable pulse to valid alu_out; legal range 1..15.
REQ-002 Parameter NUM_OPS, default 16, count of implemented opcodes, 0..NUM_OPS-1.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 req_ready  output  2  per-requester accept.
REQ-007 req_opcode  input  10  packed opcodes; [5i+4:5i] = requester i.
REQ-008 req_a  input  64  packed operand A; [32i+31:32i] = requester i.
REQ-009 req_b  input  64  packed operand B, same packing.
REQ-010 rsp_valid  output  2  one-hot response valid to owning requester.
REQ-011 rsp_ready  input  2  per-requester response accept.
REQ-012 rsp_data  output  32  result.
REQ-013 rsp_err  output  1  illegal-opcode flag.
REQ-014 alu_opcode  output  5  opcode to ALU.
REQ-015 alu_enable  output  1  ALU enable.
REQ-016 alu_a  output  32  ALU operand A.
REQ-017 alu_b  output  32  ALU operand B.
REQ-018 alu_out  input  32  ALU result.
REQ-019 busy  output  1  high whenever state != IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-021 In IDLE, req_ready[i] SHALL equal grant[i]; req_ready SHALL be 2'b00 in all other states.
REQ-022 Grant SHALL be round-robin: single valid requester wins; both valid -> requester not served last wins; pointer updates only on accept.
REQ-023 On accept (valid & ready), opcode/a/b and owner index SHALL be registered; next state ISSUE.
REQ-024 ISSUE SHALL last one cycle with alu_enable=1, alu_opcode/alu_a/alu_b driving registered values; counter loads LATENCY; next WAIT.
REQ-025 alu_opcode/alu_a/alu_b SHALL hold stable from ISSUE through end of WAIT; alu_enable=0 outside ISSUE.
REQ-026 WAIT SHALL decrement the counter each cycle; at count 1, alu_out is captured into rsp_data, rsp_err=0, next RESP.
REQ-027 Latency: accept in cycle T -> rsp_valid asserted in cycle T+2+LATENCY.
REQ-028 In RESP, rsp_valid[owner]=1 with rsp_data/rsp_err held stable until rsp_ready[owner]=1; then IDLE.
REQ-029 rsp_ready of the non-owner SHALL be ignored; no new request accepted in a RESP cycle (accept only in IDLE).
REQ-030 Throughput SHALL be one operation per LATENCY+3 cycles minimum.

Reset
REQ-031 rst SHALL force IDLE, discard any in-flight operation without response, and set pointer so requester 0 wins the first tie.
REQ-032 Reset values: req_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0, alu_enable 0, alu_opcode 0, alu_a 0, alu_b 0, busy 0.

Configuration
REQ-033 Macro ALU_SCHED_OPCHK_EN defined: accepted opcode >= NUM_OPS SHALL skip ISSUE/WAIT, go IDLE->RESP with rsp_data=0, rsp_err=1, alu_enable never asserted.
REQ-034 Macro undefined: every opcode SHALL be issued normally; rsp_err tied 0.

Structure
REQ-035 Shared package alu_pkg SHALL hold FSM state encodings, opcode constants (OP_ADD=0, OP_ADDC=1, OP_SUB=2, ... OP_NEG=15) and NUM_OPS default.
REQ-036 Round-robin grant logic SHALL be sub-module rr_arb2 (inputs valid[1:0], accept, clk, rst; output grant[1:0]).

Verification
REQ-037 Req0 opcode 0, a=5, b=7, LATENCY=1; ALU model adds -> rsp_valid=2'b01, rsp_data=12 in cycle T+3; alu_enable high exactly one cycle.
REQ-038 Both requesters valid continuously, rsp_ready=2'b11 -> grants alternate 0,1,0,1; no requester served twice in a row.
REQ-039 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0, no alu_enable pulse.
REQ-040 rst asserted in WAIT -> next cycle IDLE, busy=0, no rsp_valid; next request wins as requester 0 on tie.
REQ-041 ALU_SCHED_OPCHK_EN defined, opcode 5'd20 -> rsp_err=1, rsp_data=0 at T+1, alu_enable stays 0; undefined -> issued, rsp_err=0.
REQ-042 LATENCY=4 -> alu_a/alu_b stable ISSUE through WAIT, rsp_valid at T+6.
